// File: rtl/ram_rd_stream_if.sv
// Valid/ready word stream produced by ram_rd_stream; master drives data/valid/last.
interface ram_rd_stream_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0] m_data_o;
    logic                  m_valid_o;
    logic                  m_last_o;
    logic                  m_ready_i;

    modport master (
        output m_data_o,
        output m_valid_o,
        output m_last_o,
        input  m_ready_i
    );

    modport slave (
        input  m_data_o,
        input  m_valid_o,
        input  m_last_o,
        output m_ready_i
    );
endinterface

// File: rtl/ram_rd_stream.sv
// Walks an address range on a 1w1r RAM read port and streams the words out with backpressure.
// Optional macro RAM_RD_STREAM_STRIDE_EN adds a stride_i port (default stride is 1).
module ram_rd_stream #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   count_i,
`ifdef RAM_RD_STREAM_STRIDE_EN
    input  logic [ADDR_WIDTH-1:0] stride_i,
`endif
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] ram_a_o,
    output logic                  ram_re_o,
    input  logic [DATA_WIDTH-1:0] ram_rd_i,
    ram_rd_stream_if.master       m
);

    localparam int unsigned DEPTH = PIPE_STAGES + 2;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned PW    = $clog2(DEPTH);
    localparam logic [CW:0]         DEPTH_C  = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0]       PTR_LAST = PW'(DEPTH - 1);
    localparam logic [PW-1:0]       PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH:0]     issue_left_q, issue_left_d;
    logic [ADDR_WIDTH:0]     out_left_q, out_left_d;
    logic [PIPE_STAGES-1:0]  flag_q, flag_d;
    logic [CW-1:0]           fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                    zero_done_q, zero_done_d;
    logic [DATA_WIDTH-1:0]   mem_q [2**PW];
    logic [ADDR_WIDTH-1:0]   step;

    logic [CW-1:0]           inflight;
    logic [CW:0]             credit_used;
    logic                    accept, issue, capture, fifo_valid, pop, last_word;

`ifdef RAM_RD_STREAM_STRIDE_EN
    logic [ADDR_WIDTH-1:0]   stride_q, stride_d;
    assign step = stride_q;
`else
    assign step = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
`endif

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
            inflight = inflight + CW'(flag_q[i]);
        end
    end

    // Credits cover both FIFO entries and words still in the RAM pipe, so captures never overflow.
    assign credit_used = {1'b0, fifo_cnt_q} + {1'b0, inflight};
    assign accept      = (state_q == IDLE) && start_i && (count_i != '0);
    assign issue       = (state_q == ISSUE) && (credit_used < DEPTH_C);
    assign capture     = flag_q[PIPE_STAGES-1];
    assign fifo_valid  = (fifo_cnt_q != '0);
    assign pop         = fifo_valid && m.m_ready_i;
    assign last_word   = fifo_valid && (out_left_q == CNT_ONE);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   if (issue && (issue_left_q == CNT_ONE)) state_d = DRAIN;
            DRAIN:   if (pop && last_word) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs; ram_re stays high whenever busy so the RAM pipeline keeps moving.
    always_comb begin
        busy_o      = (state_q != IDLE);
        ram_re_o    = (state_q != IDLE);
        ram_a_o     = addr_q;
        m.m_valid_o = fifo_valid;
        m.m_data_o  = fifo_valid ? mem_q[rd_ptr_q] : '0;
        m.m_last_o  = last_word;
        done_o      = (pop && last_word) || zero_done_q;
    end

    always_comb begin
        addr_d       = addr_q;
        issue_left_d = issue_left_q;
        out_left_d   = out_left_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        zero_done_d  = (state_q == IDLE) && start_i && (count_i == '0);
        fifo_cnt_d   = fifo_cnt_q + CW'(capture) - CW'(pop);
`ifdef RAM_RD_STREAM_STRIDE_EN
        stride_d     = stride_q;
`endif
        flag_d[0] = issue;
        for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
            flag_d[i] = flag_q[i-1];
        end
        if (accept) begin
            addr_d       = base_addr_i;
            issue_left_d = count_i;
            out_left_d   = count_i;
`ifdef RAM_RD_STREAM_STRIDE_EN
            stride_d     = stride_i;
`endif
        end
        if (issue) begin
            addr_d       = addr_q + step;
            issue_left_d = issue_left_q - CNT_ONE;
        end
        if (pop) begin
            out_left_d = out_left_q - CNT_ONE;
            rd_ptr_d   = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
        end
        if (capture) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q       <= '0;
            issue_left_q <= '0;
            out_left_q   <= '0;
            flag_q       <= '0;
            fifo_cnt_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            zero_done_q  <= 1'b0;
`ifdef RAM_RD_STREAM_STRIDE_EN
            stride_q     <= '0;
`endif
        end else begin
            addr_q       <= addr_d;
            issue_left_q <= issue_left_d;
            out_left_q   <= out_left_d;
            flag_q       <= flag_d;
            fifo_cnt_q   <= fifo_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            zero_done_q  <= zero_done_d;
`ifdef RAM_RD_STREAM_STRIDE_EN
            stride_q     <= stride_d;
`endif
        end
    end

    // FIFO storage needs no reset: the output is gated by the occupancy count.
    always_ff @(posedge clk_i) begin
        if (capture) begin
            mem_q[wr_ptr_q] <= ram_rd_i;
        end
    end

endmodule

// File: tb/tb_ram_rd_stream.sv
// Scoreboard bench for ram_rd_stream driving a behavioural PIPE_STAGES-latency RAM.
module tb_ram_rd_stream;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned PS = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW:0]   cnt = '0;
    logic          busy, done, ram_re;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_rd;
    logic          ready = 1'b1;
`ifdef RAM_RD_STREAM_STRIDE_EN
    logic [AW-1:0] stride = '0;
`endif

    always #5 clk = ~clk;

    ram_rd_stream_if #(.DATA_WIDTH(DW)) sif ();
    assign sif.m_ready_i = ready;

    ram_rd_stream #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .PIPE_STAGES(PS)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .base_addr_i(base),
        .count_i    (cnt),
`ifdef RAM_RD_STREAM_STRIDE_EN
        .stride_i   (stride),
`endif
        .busy_o     (busy),
        .done_o     (done),
        .ram_a_o    (ram_a),
        .ram_re_o   (ram_re),
        .ram_rd_i   (ram_rd),
        .m          (sif)
    );

    // RAM model: mem[a] = a + 100, read pipeline advanced by ram_re
    logic [DW-1:0] ram_mem [2**AW];
    logic [DW-1:0] ram_pipe [PS];
    initial begin
        for (int i = 0; i < 2**AW; i++) ram_mem[i] = DW'(i) + 100;
        for (int i = 0; i < PS; i++) ram_pipe[i] = '0;
    end
    always @(posedge clk) begin
        if (ram_re) begin
            ram_pipe[0] <= ram_mem[ram_a];
            for (int i = 1; i < PS; i++) ram_pipe[i] <= ram_pipe[i-1];
        end
    end
    assign ram_rd = ram_pipe[PS-1];

    int n_chk = 0;
    int n_fail = 0;
    logic [DW:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_cmd(input logic [AW-1:0] b, input int n, input logic [AW-1:0] s);
        logic [AW-1:0] a;
        for (int i = 0; i < n; i++) begin
            a = b + AW'(i) * s;
            exp_q.push_back({(i == n - 1), DW'(a) + DW'(100)});
        end
    endtask

    // Ready pattern 1,0,0,1 repeating when backpressure is enabled
    bit bp_mode = 1'b0;
    int unsigned bp_phase = 0;
    always @(posedge clk) begin
        #1;
        if (bp_mode) begin
            ready = (bp_phase % 4 == 0) || (bp_phase % 4 == 3);
            bp_phase++;
        end else begin
            ready = 1'b1;
        end
    end

    // Monitor: pops scoreboard on each handshake, checks stall stability
    int hs_cnt = 0;
    int max_occ = 0;
    bit stalled = 1'b0;
    logic [DW-1:0] held;
    logic [DW:0] e;
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (int'(dut.fifo_cnt_q) > max_occ) max_occ = int'(dut.fifo_cnt_q);
            if (stalled) begin
                check("stall_valid", 64'(sif.m_valid_o), 64'd1);
                check("stall_data", 64'(sif.m_data_o), 64'(held));
            end
            if (sif.m_valid_o && ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%0h expected none", sif.m_data_o);
                end else begin
                    e = exp_q.pop_front();
                    check("data", 64'(sif.m_data_o), 64'(e[DW-1:0]));
                    check("last", 64'(sif.m_last_o), 64'(e[DW]));
                    check("done", 64'(done), 64'(e[DW]));
                end
            end
            stalled = sif.m_valid_o && !ready;
            held    = sif.m_data_o;
        end
    end

    task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] c, input logic [AW-1:0] s);
        @(posedge clk); #1;
        start = 1'b1; base = b; cnt = c;
`ifdef RAM_RD_STREAM_STRIDE_EN
        stride = s;
`else
        if (s != 1) $display("note: stride %0d ignored without stride support", s);
`endif
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_completes"}, 64'(ok), 64'd1);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_done"}, 64'(done), 64'd0);
        check({name, "_ram_re"}, 64'(ram_re), 64'd0);
        check({name, "_ram_a"}, 64'(ram_a), 64'd0);
        check({name, "_valid"}, 64'(sif.m_valid_o), 64'd0);
        check({name, "_last"}, 64'(sif.m_last_o), 64'd0);
        check({name, "_data"}, 64'(sif.m_data_o), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int target;
        bit reached;

        #2;
        check_outputs_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Simple stream with cycle-exact timing
        push_cmd(8'd5, 4, 8'd1);
        @(posedge clk); #1;
        start = 1'b1; base = 8'd5; cnt = 9'd4;
        for (int n = 0; n <= 8; n++) begin
            @(negedge clk);
            check($sformatf("t1_valid_c%0d", n), 64'(sif.m_valid_o), 64'(n >= 4 && n <= 7));
            check($sformatf("t1_done_c%0d", n), 64'(done), 64'(n == 7));
            check($sformatf("t1_busy_c%0d", n), 64'(busy), 64'(n >= 1 && n <= 7));
            check($sformatf("t1_re_c%0d", n), 64'(ram_re), 64'(n >= 1 && n <= 7));
            if (n == 1) check("t1_first_addr", 64'(ram_a), 64'd5);
            @(posedge clk); #1;
            if (n == 0) start = 1'b0;
        end

        // Wrap from top of RAM
        push_cmd(8'd254, 4, 8'd1);
        do_start(8'd254, 9'd4, 8'd1);
        wait_idle(100, "wrap");

        // Backpressure
        bp_mode = 1'b1;
        max_occ = 0;
        push_cmd(8'd30, 16, 8'd1);
        do_start(8'd30, 9'd16, 8'd1);
        wait_idle(400, "backpressure");
        bp_mode = 1'b0;
        check("max_occupancy_ok", 64'(max_occ <= int'(PS) + 2), 64'd1);

        // Zero count
        @(posedge clk); #1;
        start = 1'b1; base = 8'd9; cnt = '0;
        for (int n = 0; n <= 4; n++) begin
            @(negedge clk);
            check($sformatf("zero_done_c%0d", n), 64'(done), 64'(n == 1));
            check($sformatf("zero_re_c%0d", n), 64'(ram_re), 64'd0);
            check($sformatf("zero_busy_c%0d", n), 64'(busy), 64'd0);
            @(posedge clk); #1;
            if (n == 0) start = 1'b0;
        end

        // Start while busy must be ignored
        push_cmd(8'd60, 6, 8'd1);
        do_start(8'd60, 9'd6, 8'd1);
        @(posedge clk); #1;
        start = 1'b1; base = 8'd0; cnt = 9'd2;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(100, "busy_start");
        repeat (6) @(negedge clk);
        check("busy_start_idle", 64'(busy), 64'd0);

        // Reset after 3 of 10 words
        push_cmd(8'd20, 10, 8'd1);
        target = hs_cnt + 3;
        do_start(8'd20, 9'd10, 8'd1);
        reached = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (hs_cnt >= target) begin
                reached = 1'b1;
                break;
            end
        end
        check("reset_three_words", 64'(reached), 64'd1);
        #1 rst = 1'b1;
        #1;
        check_outputs_zero("midreset");
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        push_cmd(8'd40, 3, 8'd1);
        do_start(8'd40, 9'd3, 8'd1);
        wait_idle(100, "after_reset");

`ifdef RAM_RD_STREAM_STRIDE_EN
        push_cmd(8'd0, 4, 8'd3);
        do_start(8'd0, 9'd4, 8'd3);
        wait_idle(100, "stride");
`endif

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_rd_stream.md
# ram_rd_stream

Read-side streamer for the 1-write/1-read block RAMs used throughout the NTT datapath. On a start command it walks an address range on the RAM read port, absorbs the RAM's fixed read latency, and presents the words as a valid/ready stream with backpressure. It sits between any `ram_1w1r_1clk` instance and a downstream consumer such as a butterfly stage or a host DMA, and sustains one word per cycle when the consumer never stalls.

## Interface

Parameters:
- `ADDR_WIDTH`, default 8: RAM address width.
- `DATA_WIDTH`, default 32: word width.
- `PIPE_STAGES`, default 2: RAM read latency in cycles. Must be ≥1 and must equal the attached RAM's setting.

Ports:
- `clk_i`, input, 1: the single clock.
- `rst_i`, input, 1: reset, asynchronous, active-high.
- `start_i`, input, 1: start command. Sampled only in IDLE.
- `base_addr_i`, input, ADDR_WIDTH: first address. Sampled with `start_i`.
- `count_i`, input, ADDR_WIDTH+1: number of words to read. Sampled with `start_i`.
- `busy_o`, output, 1: high while not in IDLE.
- `done_o`, output, 1: one-cycle pulse when the last word is accepted downstream.
- `ram_a_o`, output, ADDR_WIDTH: RAM read address.
- `ram_re_o`, output, 1: RAM read enable. Also serves as the RAM output-register enable.
- `ram_rd_i`, input, DATA_WIDTH: RAM read data.
- `m_data_o`, output, DATA_WIDTH: stream data.
- `m_valid_o`, output, 1: stream valid.
- `m_last_o`, output, 1: marks the final word of the command.
- `m_ready_i`, input, 1: downstream ready.

## Operation

- **FSM states:** IDLE, ISSUE, DRAIN.
- **IDLE → ISSUE:** on `start_i` with `count_i` ≠ 0. The block latches `base_addr_i` and `count_i`.
- **`start_i` with `count_i` = 0:** no read is issued, no state change, and `done_o` pulses the next cycle.
- **Issue condition in ISSUE:** one read is issued per cycle when `fifo_count + inflight < PIPE_STAGES+2`.
  - When a read issues, `ram_a_o` holds the current address. The address then increments modulo 2^ADDR_WIDTH, so it wraps from the top of the RAM to 0.
  - An internal PIPE_STAGES-deep flag shift register tracks which cycles carried real issues.
- **`ram_re_o`:** held high for every cycle in ISSUE and DRAIN, including cycles with no issue. This keeps the RAM pipeline advancing. The flag shift register, not `ram_re_o`, decides which returning words are captured.
- **Capture:** a word is captured into an internal show-ahead FIFO of depth PIPE_STAGES+2 when its flag exits the shift register. The credit rule above guarantees the FIFO never overflows.
- **ISSUE → DRAIN:** after the last address issues.
- **DRAIN → IDLE:** on the handshake (`m_valid_o & m_ready_i`) of the last word. `done_o` pulses in that same cycle. `busy_o` goes low the following cycle.
- **`m_last_o`:** high exactly when the FIFO head is the final word of the command.
- **`start_i` outside IDLE:** ignored, with no effect on the running command.
- **Reset at any time:** returns to IDLE and empties the FIFO, flags and counters. In-flight RAM data is discarded.
- **Output reset values:** all outputs 0, and `m_data_o` = 0.

## Timing

- Address presented in cycle t → `ram_rd_i` valid in cycle t+PIPE_STAGES → captured at the end of that cycle → `m_valid_o` high from cycle t+PIPE_STAGES+1.
- `start_i` in cycle 0 → first address in cycle 1 → first `m_valid_o` in cycle PIPE_STAGES+2 (cycle 4 at default).
- With `m_ready_i` held high, one word is delivered per cycle with no bubbles.
- `m_valid_o` stays high and `m_data_o` stays stable until the handshake.
- A FIFO pop and a capture in the same cycle are both honoured.
- The pop frees its credit in the following cycle.

## Configuration

- **`RAM_RD_STREAM_STRIDE_EN` defined:**
  - Adds input `stride_i` (ADDR_WIDTH bits), sampled with `start_i`.
  - The address advances by `stride_i` modulo 2^ADDR_WIDTH.
  - `stride_i` = 0 re-reads the same address `count_i` times.
- **Undefined:** no `stride_i` port; the stride is fixed at 1.

## Test plan

- **Simple stream:** RAM preloaded with mem[a] = a+100. start, base 5, count 4, ready always high, PIPE_STAGES 2.
  - Data 105, 106, 107, 108 on `m_data_o` in cycles 4–7.
  - `m_last_o` with 108; `done_o` in cycle 7.
- **Wrap:** ADDR_WIDTH 8, base 254, count 4.
  - Addresses 254, 255, 0, 1.
  - Data order matches those addresses.
- **Backpressure:** `m_ready_i` toggles 1,0,0,1,… over 16 words.
  - All 16 words are delivered in order with no duplicates or drops.
  - `m_data_o` is stable while stalled.
  - FIFO occupancy never exceeds 4.
- **Zero count and busy start:**
  - count 0 → `done_o` next cycle and `ram_re_o` never asserts.
  - A second `start_i` mid-command does not alter the sequence.
- **Reset mid-operation:** assert `rst_i` after 3 of 10 words.
  - All outputs go to 0 immediately.
  - A fresh command afterwards returns correct data from its base.
- **Stride (macro defined):** base 0, stride 3, count 4.
  - Addresses 0, 3, 6, 9.
